// File: rtl/memory_param.sv
// memory_param: parametrised synchronous scratch RAM with registered read,
// optional write-to-read bypass, per-word written flags and sticky error.
//
// Ports:
//   clk      rising-edge clock for all state
//   reset    synchronous active-low reset (0 = reset)
//   activate block enable; 0 masks write and read
//   write    write request, addrin/datain give address and data
//   read     read request, addrout gives address
//   err_clr  clears error and err_code
//   dataout  registered read data
//   rvalid   one-cycle pulse, dataout updated this cycle
//   error    sticky error flag
//   err_code cause of latest error: 01 bad write addr,
//            10 bad read addr, 11 read of unwritten word
module memory_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              activate,
    input  logic              write,
    input  logic [ADDR_W-1:0] addrin,
    input  logic [DATA_W-1:0] datain,
    input  logic              read,
    input  logic [ADDR_W-1:0] addrout,
    input  logic              err_clr,
    output logic [DATA_W-1:0] dataout,
    output logic              rvalid,
    output logic              error,
    output logic [1:0]        err_code
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH);

    localparam logic [1:0] ERR_WADDR = 2'b01;
    localparam logic [1:0] ERR_RADDR = 2'b10;
    localparam logic [1:0] ERR_UNWR  = 2'b11;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  written;

    logic             wr_en;
    logic             rd_en;
    logic             wr_in;
    logic             rd_in;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic             wr_ok;
    logic             wr_bad;
    logic             byp_hit;
    logic             rd_written;

    logic [DATA_W-1:0] rd_data;
    logic              rd_err;
    logic [1:0]        rd_code;
    logic              ev;
    logic [1:0]        ev_code;

    assign wr_en  = activate & write;
    assign rd_en  = activate & read;
    assign wr_in  = {1'b0, addrin} < LIMIT;
    assign rd_in  = {1'b0, addrout} < LIMIT;
    assign wr_idx = IDX_W'(addrin);
    assign rd_idx = IDX_W'(addrout);
    assign wr_ok  = wr_en & wr_in;
    assign wr_bad = wr_en & ~wr_in;

    // A colliding in-range write is forwarded only when BYPASS is set;
    // otherwise the read sees the pre-write contents and flag.
    assign byp_hit    = BYPASS && wr_ok && rd_in && (addrin == addrout);
    assign rd_written = written[rd_idx];

    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        rd_code = 2'b00;
        unique case (1'b1)
            !rd_in: begin
                rd_err  = 1'b1;
                rd_code = ERR_RADDR;
            end
            byp_hit: begin
                rd_data = datain;
            end
            rd_in && !byp_hit && !rd_written: begin
                rd_err  = 1'b1;
                rd_code = ERR_UNWR;
            end
            default: begin
                rd_data = mem[rd_idx];
            end
        endcase
    end

    // Read-side cause takes priority over a simultaneous bad write.
    assign ev      = (rd_en & rd_err) | wr_bad;
    assign ev_code = (rd_en & rd_err) ? rd_code : ERR_WADDR;

    // Array carries no reset so it can map onto RAM; reset still
    // suppresses a write presented in the reset cycle.
    always_ff @(posedge clk) begin
        if (reset && wr_ok) begin
            mem[wr_idx] <= datain;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            written  <= '0;
            dataout  <= '0;
            rvalid   <= 1'b0;
            error    <= 1'b0;
            err_code <= 2'b00;
        end else begin
            if (wr_ok) begin
                written[wr_idx] <= 1'b1;
            end
            rvalid <= rd_en;
            if (rd_en) begin
                dataout <= rd_data;
            end
            if (ev) begin
                error    <= 1'b1;
                err_code <= ev_code;
            end else if (err_clr) begin
                error    <= 1'b0;
                err_code <= 2'b00;
            end
        end
    end

endmodule

// File: tb/tb_memory_param.sv
// tb_memory_param: directed bench for memory_param in three builds
// (bypass, no bypass, DEPTH=12) driven by a shared stimulus stream.
module tb_memory_param;

    localparam int NI = 3;
    localparam int DEP [NI] = '{16, 16, 12};
    localparam bit BYP [NI] = '{1'b1, 1'b0, 1'b1};

    logic       clk = 1'b0;
    logic       reset;
    logic       activate;
    logic       write;
    logic [3:0] addrin;
    logic [7:0] datain;
    logic       read;
    logic [3:0] addrout;
    logic       err_clr;

    logic [7:0] dout [NI];
    logic       rv   [NI];
    logic       er   [NI];
    logic [1:0] cd   [NI];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    memory_param #(.DATA_W(8), .ADDR_W(4), .DEPTH(16), .BYPASS(1'b1)) u_byp (
        .clk(clk), .reset(reset), .activate(activate), .write(write),
        .addrin(addrin), .datain(datain), .read(read), .addrout(addrout),
        .err_clr(err_clr), .dataout(dout[0]), .rvalid(rv[0]),
        .error(er[0]), .err_code(cd[0])
    );

    memory_param #(.DATA_W(8), .ADDR_W(4), .DEPTH(16), .BYPASS(1'b0)) u_nobyp (
        .clk(clk), .reset(reset), .activate(activate), .write(write),
        .addrin(addrin), .datain(datain), .read(read), .addrout(addrout),
        .err_clr(err_clr), .dataout(dout[1]), .rvalid(rv[1]),
        .error(er[1]), .err_code(cd[1])
    );

    memory_param #(.DATA_W(8), .ADDR_W(4), .DEPTH(12), .BYPASS(1'b1)) u_d12 (
        .clk(clk), .reset(reset), .activate(activate), .write(write),
        .addrin(addrin), .datain(datain), .read(read), .addrout(addrout),
        .err_clr(err_clr), .dataout(dout[2]), .rvalid(rv[2]),
        .error(er[2]), .err_code(cd[2])
    );

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, got, exp);
        end
    endtask

    // Reference model: a word array, a written set and the sticky error,
    // advanced once per rising edge from the sampled request.
    logic [7:0] m_mem [NI][16];
    logic       m_wr  [NI][16];
    logic [7:0] m_do  [NI];
    logic       m_rv  [NI];
    logic       m_er  [NI];
    logic [1:0] m_cd  [NI];
    bit         m_ready = 1'b0;

    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (!reset) begin
                for (int a = 0; a < 16; a++) m_wr[k][a] = 1'b0;
                m_do[k] = 8'h00;
                m_rv[k] = 1'b0;
                m_er[k] = 1'b0;
                m_cd[k] = 2'b00;
            end else begin
                int       wa;
                int       ra;
                bit       wgood;
                bit       ev;
                bit [1:0] code;
                wa    = int'(addrin);
                ra    = int'(addrout);
                wgood = activate && write && (wa < DEP[k]);
                ev    = 1'b0;
                code  = 2'b00;
                if (activate && write && !(wa < DEP[k])) begin
                    ev   = 1'b1;
                    code = 2'b01;
                end
                m_rv[k] = activate && read;
                if (activate && read) begin
                    if (ra >= DEP[k]) begin
                        m_do[k] = 8'h00;
                        ev      = 1'b1;
                        code    = 2'b10;
                    end else if (BYP[k] && wgood && wa == ra) begin
                        m_do[k] = datain;
                    end else if (!m_wr[k][ra]) begin
                        m_do[k] = 8'h00;
                        ev      = 1'b1;
                        code    = 2'b11;
                    end else begin
                        m_do[k] = m_mem[k][ra];
                    end
                end
                if (wgood) begin
                    m_mem[k][wa] = datain;
                    m_wr[k][wa]  = 1'b1;
                end
                if (ev) begin
                    m_er[k] = 1'b1;
                    m_cd[k] = code;
                end else if (err_clr) begin
                    m_er[k] = 1'b0;
                    m_cd[k] = 2'b00;
                end
            end
        end
        if (!reset) m_ready = 1'b1;
    end

    always @(posedge clk) begin
        #1;
        if (m_ready) begin
            for (int k = 0; k < NI; k++) begin
                chk($sformatf("model dataout u%0d", k), 32'(dout[k]), 32'(m_do[k]));
                chk($sformatf("model rvalid u%0d", k), 32'(rv[k]), 32'(m_rv[k]));
                chk($sformatf("model error u%0d", k), 32'(er[k]), 32'(m_er[k]));
                chk($sformatf("model err_code u%0d", k), 32'(cd[k]), 32'(m_cd[k]));
            end
        end
    end

    task automatic step(input logic rst, input logic act, input logic wr,
                        input logic [3:0] wa, input logic [7:0] wd,
                        input logic rd, input logic [3:0] ra,
                        input logic clr);
        reset    = rst;
        activate = act;
        write    = wr;
        addrin   = wa;
        datain   = wd;
        read     = rd;
        addrout  = ra;
        err_clr  = clr;
        @(negedge clk);
    endtask

    task automatic wr_word(input logic [3:0] a, input logic [7:0] d);
        step(1'b1, 1'b1, 1'b1, a, d, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic rd_word(input logic [3:0] a);
        step(1'b1, 1'b1, 1'b0, 4'd0, 8'h00, 1'b1, a, 1'b0);
    endtask

    task automatic idle();
        step(1'b1, 1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic clear();
        step(1'b1, 1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b1);
    endtask

    initial begin
        step(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0);
        chk("reset dataout", 32'(dout[0]), 32'h00);
        chk("reset rvalid", 32'(rv[0]), 32'h0);
        chk("reset error", 32'(er[0]), 32'h0);
        chk("reset err_code", 32'(cd[0]), 32'h0);

        wr_word(4'd3, 8'hA5);
        chk("write no rvalid", 32'(rv[0]), 32'h0);
        rd_word(4'd3);
        chk("read3 dataout", 32'(dout[0]), 32'hA5);
        chk("read3 rvalid", 32'(rv[0]), 32'h1);
        chk("read3 error", 32'(er[0]), 32'h0);
        idle();
        chk("idle rvalid drop", 32'(rv[0]), 32'h0);
        chk("idle dataout hold", 32'(dout[0]), 32'hA5);

        rd_word(4'd7);
        chk("unwr dataout", 32'(dout[0]), 32'h00);
        chk("unwr rvalid", 32'(rv[0]), 32'h1);
        chk("unwr error", 32'(er[0]), 32'h1);
        chk("unwr err_code", 32'(cd[0]), 32'h3);
        clear();
        chk("clr error", 32'(er[0]), 32'h0);
        chk("clr err_code", 32'(cd[0]), 32'h0);

        step(1'b1, 1'b1, 1'b1, 4'd5, 8'h3C, 1'b1, 4'd5, 1'b0);
        chk("coll byp dataout", 32'(dout[0]), 32'h3C);
        chk("coll byp error", 32'(er[0]), 32'h0);
        chk("coll nobyp unwr dataout", 32'(dout[1]), 32'h00);
        chk("coll nobyp unwr code", 32'(cd[1]), 32'h3);
        clear();
        wr_word(4'd5, 8'h11);
        step(1'b1, 1'b1, 1'b1, 4'd5, 8'h3C, 1'b1, 4'd5, 1'b0);
        chk("coll nobyp old", 32'(dout[1]), 32'h11);
        chk("coll nobyp error", 32'(er[1]), 32'h0);
        chk("coll byp new", 32'(dout[0]), 32'h3C);
        rd_word(4'd5);
        chk("after coll nobyp", 32'(dout[1]), 32'h3C);

        wr_word(4'd13, 8'hFF);
        chk("oor write error", 32'(er[2]), 32'h1);
        chk("oor write code", 32'(cd[2]), 32'h1);
        chk("inrange write no err", 32'(er[0]), 32'h0);
        rd_word(4'd12);
        chk("oor read code", 32'(cd[2]), 32'h2);
        chk("oor read dataout", 32'(dout[2]), 32'h00);
        chk("oor read rvalid", 32'(rv[2]), 32'h1);
        clear();
        step(1'b1, 1'b1, 1'b1, 4'd13, 8'hFF, 1'b0, 4'd0, 1'b1);
        chk("event beats clr err", 32'(er[2]), 32'h1);
        chk("event beats clr code", 32'(cd[2]), 32'h1);
        step(1'b1, 1'b1, 1'b1, 4'd13, 8'hFF, 1'b1, 4'd14, 1'b0);
        chk("dual bad read wins", 32'(cd[2]), 32'h2);
        clear();

        for (int i = 0; i < 16; i++) wr_word(4'(i), 8'(i));
        for (int i = 0; i < 16; i++) begin
            rd_word(4'(i));
            chk($sformatf("stream data %0d", i), 32'(dout[0]), 32'(i));
            chk($sformatf("stream valid %0d", i), 32'(rv[0]), 32'h1);
        end

        step(1'b1, 1'b0, 1'b1, 4'd1, 8'h77, 1'b1, 4'd1, 1'b0);
        chk("gated rvalid", 32'(rv[0]), 32'h0);
        chk("gated dataout hold", 32'(dout[0]), 32'h0F);
        chk("gated no error", 32'(er[0]), 32'h0);
        chk("gated d12 code hold", 32'(cd[2]), 32'h2);
        rd_word(4'd1);
        chk("gated no write", 32'(dout[0]), 32'h01);

        step(1'b0, 1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 4'd3, 1'b0);
        chk("midrst rvalid", 32'(rv[0]), 32'h0);
        chk("midrst dataout", 32'(dout[0]), 32'h00);
        chk("midrst d12 error", 32'(er[2]), 32'h0);
        rd_word(4'd3);
        chk("post rst dataout", 32'(dout[0]), 32'h00);
        chk("post rst error", 32'(er[0]), 32'h1);
        chk("post rst code", 32'(cd[0]), 32'h3);
        idle();
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
